// File: rtl/vga_pkg.sv
// Shared constants, register map and clear-engine state type for the VGA frame buffer.
`default_nettype none

package vga_pkg;

  localparam logic [7:0] REG_X      = 8'd0;
  localparam logic [7:0] REG_Y      = 8'd1;
  localparam logic [7:0] REG_PIXEL  = 8'd2;
  localparam logic [7:0] REG_COL_BG = 8'd3;
  localparam logic [7:0] REG_COL_FG = 8'd4;
  localparam logic [7:0] REG_CTRL   = 8'd5;
  localparam logic [7:0] REG_COUNT  = 8'd6;

  localparam int H_PIX    = 160;
  localparam int V_PIX    = 120;
  localparam int FB_DEPTH = 32768;
  localparam int FB_AW    = 15;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

endpackage

`default_nettype wire

// File: rtl/vga_frame_buffer_if.sv
// Processor bus and display-side signal bundle of the VGA frame buffer.
`default_nettype none

interface vga_frame_buffer_if;
  logic [7:0]  BUS_ADDR;
  logic [7:0]  BUS_DATA_IN;
  logic        BUS_WE;
  logic [7:0]  BUS_DATA_OUT;
  logic        BUS_DATA_OE;
  logic [14:0] VGA_ADDR;
  logic [7:0]  VGA_DATA;
  logic [15:0] CONFIG_COLOURS;

  modport master (
    output BUS_ADDR, BUS_DATA_IN, BUS_WE, VGA_ADDR,
    input  BUS_DATA_OUT, BUS_DATA_OE, VGA_DATA, CONFIG_COLOURS
  );

  modport slave (
    input  BUS_ADDR, BUS_DATA_IN, BUS_WE, VGA_ADDR,
    output BUS_DATA_OUT, BUS_DATA_OE, VGA_DATA, CONFIG_COLOURS
  );
endinterface

`default_nettype wire

// File: rtl/vga_frame_ram.sv
// 32768x1 frame store: one synchronous write port, one registered read-first read port.
`default_nettype none

module vga_frame_ram
  import vga_pkg::*;
#(
  parameter int DEPTH = FB_DEPTH,
  parameter int AW    = FB_AW
) (
  input  wire logic          clk,
  input  wire logic          i_we,
  input  wire logic [AW-1:0] i_waddr,
  input  wire logic          i_wdata,
  input  wire logic [AW-1:0] i_raddr,
  output logic               o_rdata
);

  logic r_mem [0:DEPTH-1];
  logic r_rdata;

  // Read samples the array before the write lands, giving old data on a collision.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/vga_frame_buffer.sv
// //////////////////////////////////////////////////////////////////////////
// // Module : vga_frame_buffer
// // Desc   : 160x120 1bpp frame buffer with bus registers, clear engine and
// //          colour-mapped display read port. Option: VGA_FB_AUTOINC_EN.
// // Rev    : 1.0  initial release
// //////////////////////////////////////////////////////////////////////////
`default_nettype none

module vga_frame_buffer
  import vga_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR       = 8'hB0,
  parameter logic [15:0] DEFAULT_COLOURS = 16'hFF00
) (
  input wire logic         CLK,
  input wire logic         RESET,
  vga_frame_buffer_if.slave bus
);

  localparam logic [FB_AW-1:0] c_LAST_ADDR = FB_AW'(FB_DEPTH - 1);

  clr_state_t       r_state;
  clr_state_t       w_state_nxt;
  logic [FB_AW-1:0] r_counter;
  logic             r_fill;
  logic [7:0]       r_x;
  logic [6:0]       r_y;
  logic [15:0]      r_colours;
  logic [7:0]       r_bus_data;
  logic             r_bus_oe;
  logic             r_vga_valid;

  logic [7:0]       w_offset;
  logic             w_hit;
  logic             w_busy;
  logic             w_wr_pix;
  logic             w_wr_ctrl;
  logic             w_pix_accept;
  logic             w_clr_start;
  logic [7:0]       w_rd_data;
  logic             w_ram_we;
  logic [FB_AW-1:0] w_ram_waddr;
  logic             w_ram_wdata;
  logic             w_pix_bit;

  assign w_offset     = bus.BUS_ADDR - BASE_ADDR;
  assign w_hit        = (w_offset < REG_COUNT);
  assign w_busy       = (r_state == CLEAR);
  assign w_wr_pix     = bus.BUS_WE && (w_offset == REG_PIXEL);
  assign w_wr_ctrl    = bus.BUS_WE && (w_offset == REG_CTRL);
  assign w_pix_accept = w_wr_pix && !w_busy;
  assign w_clr_start  = w_wr_ctrl && !w_busy;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state   <= IDLE;
      r_counter <= '0;
      r_fill    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_busy) begin
        r_counter <= r_counter + 1'b1;
      end else if (w_clr_start) begin
        r_counter <= '0;
        r_fill    <= bus.BUS_DATA_IN[0];
      end
    end
  end

  // Clear engine owns the write port while busy, so pixel writes are dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_ram_we    = 1'b0;
    w_ram_waddr = {r_y, r_x};
    w_ram_wdata = bus.BUS_DATA_IN[0];
    case (r_state)
      IDLE: begin
        if (w_clr_start) begin
          w_state_nxt = CLEAR;
        end
        w_ram_we = w_pix_accept;
      end
      CLEAR: begin
        w_ram_we    = 1'b1;
        w_ram_waddr = r_counter;
        w_ram_wdata = r_fill;
        if (r_counter == c_LAST_ADDR) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef VGA_FB_AUTOINC_EN
  localparam logic [7:0] c_X_LAST = 8'(H_PIX - 1);
  localparam logic [6:0] c_Y_LAST = 7'(V_PIX - 1);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_x <= '0;
      r_y <= '0;
    end else begin
      if (bus.BUS_WE && (w_offset == REG_X)) begin
        r_x <= bus.BUS_DATA_IN;
      end else if (w_pix_accept) begin
        r_x <= (r_x >= c_X_LAST) ? 8'd0 : r_x + 8'd1;
      end
      if (bus.BUS_WE && (w_offset == REG_Y)) begin
        r_y <= bus.BUS_DATA_IN[6:0];
      end else if (w_pix_accept && (r_x >= c_X_LAST)) begin
        r_y <= (r_y >= c_Y_LAST) ? 7'd0 : r_y + 7'd1;
      end
    end
  end
`else
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_x <= '0;
      r_y <= '0;
    end else begin
      if (bus.BUS_WE && (w_offset == REG_X)) begin
        r_x <= bus.BUS_DATA_IN;
      end
      if (bus.BUS_WE && (w_offset == REG_Y)) begin
        r_y <= bus.BUS_DATA_IN[6:0];
      end
    end
  end
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_colours <= DEFAULT_COLOURS;
    end else if (bus.BUS_WE) begin
      if (w_offset == REG_COL_BG) begin
        r_colours[7:0] <= bus.BUS_DATA_IN;
      end
      if (w_offset == REG_COL_FG) begin
        r_colours[15:8] <= bus.BUS_DATA_IN;
      end
    end
  end

  always_comb begin
    w_rd_data = 8'h00;
    case (w_offset)
      REG_X:      w_rd_data = r_x;
      REG_Y:      w_rd_data = {1'b0, r_y};
      REG_COL_BG: w_rd_data = r_colours[7:0];
      REG_COL_FG: w_rd_data = r_colours[15:8];
      REG_CTRL:   w_rd_data = {7'b0, w_busy};
      default:    w_rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_bus_data <= 8'h00;
      r_bus_oe   <= 1'b0;
    end else if (!bus.BUS_WE && w_hit) begin
      r_bus_data <= w_rd_data;
      r_bus_oe   <= 1'b1;
    end else begin
      r_bus_data <= 8'h00;
      r_bus_oe   <= 1'b0;
    end
  end

  vga_frame_ram #(
    .DEPTH (FB_DEPTH),
    .AW    (FB_AW)
  ) u_ram (
    .clk     (CLK),
    .i_we    (w_ram_we),
    .i_waddr (w_ram_waddr),
    .i_wdata (w_ram_wdata),
    .i_raddr (bus.VGA_ADDR),
    .o_rdata (w_pix_bit)
  );

  // The RAM read register has no reset; blank the output until it has loaded once.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_vga_valid <= 1'b0;
    end else begin
      r_vga_valid <= 1'b1;
    end
  end

  assign bus.VGA_DATA       = !r_vga_valid ? 8'h00 :
                              (w_pix_bit ? r_colours[15:8] : r_colours[7:0]);
  assign bus.CONFIG_COLOURS = r_colours;
  assign bus.BUS_DATA_OUT   = r_bus_data;
  assign bus.BUS_DATA_OE    = r_bus_oe;

endmodule

`default_nettype wire
